// File: rtl/fpga_ce_gen.sv
// Programmable clock-enable strobe generator: free-running or counted-burst strobes
// every D cycles. Optional mid-period strobe output E_mid_o under FPGA_CE_GEN_MID_EN.
module fpga_ce_gen #(
  parameter int DIV_W     = 16,
  parameter int CNT_W     = 8,
  parameter int DIV_RESET = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             run_i,
  input  logic             burst_start_i,
  input  logic [CNT_W-1:0] burst_len_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_valid_i,
  output logic             div_ready_o,
  output logic             E_o,
`ifdef FPGA_CE_GEN_MID_EN
  output logic             E_mid_o,
`endif
  output logic             busy_o,
  output logic             burst_done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FREE  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RESET);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;

  logic             active;
  logic             strobe;
  logic             accept;
  logic             leave;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] pend_eff;

  // Zero divisors behave as one so the period counter never underflows.
  assign div_eff  = (div_q == '0) ? DIV_ONE : div_q;
  assign pend_eff = (pend_val_q == '0) ? DIV_ONE : pend_val_q;

  assign active = (state_q != ST_IDLE);
  assign strobe = active && (cnt_q == '0);
  assign accept = div_valid_i && div_ready_o;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    leave      = 1'b0;

    if (active) begin
      if (strobe) begin
        if (pend_q) begin
          div_d  = pend_val_q;
          pend_d = 1'b0;
          cnt_d  = pend_eff - DIV_ONE;
        end else begin
          cnt_d = div_eff - DIV_ONE;
        end
      end else begin
        cnt_d = cnt_q - DIV_ONE;
      end
      // accept implies pend_q is clear, so this never collides with the apply above
      if (accept) begin
        pend_d     = 1'b1;
        pend_val_d = div_i;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          div_d = div_i;
        end
        if (burst_start_i && (burst_len_i != '0)) begin
          state_d = ST_BURST;
          rem_d   = burst_len_i;
          cnt_d   = '0;
        end else if (run_i) begin
          state_d = ST_FREE;
          cnt_d   = '0;
        end
      end
      ST_FREE: begin
        if (!run_i) begin
          leave = 1'b1;
        end
      end
      ST_BURST: begin
        if (strobe) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            leave  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Returning to IDLE folds any pending divisor straight into D.
    if (leave) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
      if (accept) begin
        div_d = div_i;
      end else if (pend_q) begin
        div_d = pend_val_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= DIV_INIT;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      rem_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
    end
  end

  assign E_o          = strobe;
  assign busy_o       = active;
  assign burst_done_o = done_q;
  assign div_ready_o  = !pend_q;

`ifdef FPGA_CE_GEN_MID_EN
  assign E_mid_o = active && (div_eff != DIV_ONE) && (cnt_q == (div_eff >> 1));
`endif

endmodule

// File: tb/tb_fpga_ce_gen.sv
// Directed bench for fpga_ce_gen: strobe spacing, bursts, divider handshake, reset abort.
// Mid-period strobe is also checked when FPGA_CE_GEN_MID_EN is defined.
module tb_fpga_ce_gen;

  localparam int DIV_W = 16;
  localparam int CNT_W = 8;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             run_i;
  logic             burst_start_i;
  logic [CNT_W-1:0] burst_len_i;
  logic [DIV_W-1:0] div_i;
  logic             div_valid_i;
  logic             div_ready_o;
  logic             E_o;
  logic             busy_o;
  logic             burst_done_o;
`ifdef FPGA_CE_GEN_MID_EN
  logic             E_mid_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] e_v, b_v, d_v, r_v, m_v;

  always #5 clk_i = ~clk_i;

  fpga_ce_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W), .DIV_RESET(4)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .run_i        (run_i),
    .burst_start_i(burst_start_i),
    .burst_len_i  (burst_len_i),
    .div_i        (div_i),
    .div_valid_i  (div_valid_i),
    .div_ready_o  (div_ready_o),
    .E_o          (E_o),
`ifdef FPGA_CE_GEN_MID_EN
    .E_mid_o      (E_mid_o),
`endif
    .busy_o       (busy_o),
    .burst_done_o (burst_done_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Runs n cycles, sampling outputs into bit vectors; pulse inputs are dropped after the first edge.
  task automatic collect(input int n);
    e_v = '0; b_v = '0; d_v = '0; r_v = '0; m_v = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      e_v[i] = E_o;
      b_v[i] = busy_o;
      d_v[i] = burst_done_o;
      r_v[i] = div_ready_o;
`ifdef FPGA_CE_GEN_MID_EN
      m_v[i] = E_mid_o;
`endif
      burst_start_i = 1'b0;
      div_valid_i   = 1'b0;
    end
  endtask

  task automatic write_div(input logic [DIV_W-1:0] v);
    div_i       = v;
    div_valid_i = 1'b1;
    collect(1);
  endtask

  initial begin
    reset_i = 1'b1; run_i = 1'b0; burst_start_i = 1'b0;
    burst_len_i = '0; div_i = '0; div_valid_i = 1'b0;
    collect(2);
    reset_i = 1'b0;
    check("rst_outputs", {28'd0, E_o, busy_o, burst_done_o, div_ready_o}, 32'h1);

    // Free-running at the reset divisor of 4
    run_i = 1'b1;
    collect(12);
    check("free_d4_e", e_v, 32'h111);
    check("free_d4_busy", b_v, 32'hFFF);
`ifdef FPGA_CE_GEN_MID_EN
    check("free_d4_mid", m_v, 32'h444);
`endif
    run_i = 1'b0;
    collect(4);
    check("free_stop_e", e_v, 32'h0);
    check("free_stop_busy", b_v, 32'h0);

    // Burst of 5 with D=3
    write_div(16'd3);
    burst_start_i = 1'b1; burst_len_i = 8'd5;
    collect(20);
    check("burst5_e", e_v, 32'h1249);
    check("burst5_done", d_v, 32'h2000);
    check("burst5_busy", b_v, 32'h1FFF);

    // Mid-period divisor change while free-running at D=4
    write_div(16'd4);
    run_i = 1'b1;
    e_v = '0; r_v = '0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      e_v[c-1] = E_o;
      r_v[c-1] = div_ready_o;
      if (c == 2) begin div_i = 16'd2; div_valid_i = 1'b1; end
      if (c == 3) div_i = 16'd7;
      if (c == 5) div_valid_i = 1'b0;
    end
    check("pend_e", e_v, 32'h551);
    check("pend_ready", r_v, 32'hFE3);
    run_i = 1'b0;
    collect(2);

    // D=0 and D=1 both strobe every cycle
    write_div(16'd0);
    run_i = 1'b1;
    collect(6);
    check("d0_e", e_v, 32'h3F);
    run_i = 1'b0;
    collect(2);
    check("d0_stop_e", {31'd0, e_v[1]}, 32'h0);
    write_div(16'd1);
    run_i = 1'b1;
    collect(6);
    check("d1_e", e_v, 32'h3F);
    run_i = 1'b0;
    collect(2);

    // Burst wins over run, then FREE resumes one cycle after the burst ends
    write_div(16'd2);
    burst_start_i = 1'b1; burst_len_i = 8'd2; run_i = 1'b1;
    collect(8);
    check("prio_e", e_v, 32'h55);
    check("prio_done", d_v, 32'h8);
    check("prio_busy", b_v, 32'hF7);
    run_i = 1'b0;
    collect(3);

    // Zero-length burst is ignored
    burst_start_i = 1'b1; burst_len_i = 8'd0;
    collect(4);
    check("len0_busy", b_v, 32'h0);
    check("len0_done", d_v, 32'h0);
    check("len0_e", e_v, 32'h0);

    // Reset mid-burst after two strobes (remaining=3), with D=3
    write_div(16'd3);
    burst_start_i = 1'b1; burst_len_i = 8'd5;
    collect(5);
    check("abort_pre_e", e_v, 32'h09);
    reset_i = 1'b1;
    collect(1);
    reset_i = 1'b0;
    check("abort_outputs", {28'd0, E_o, busy_o, burst_done_o, div_ready_o}, 32'h1);
    run_i = 1'b1;
    collect(6);
    check("abort_div_reset_e", e_v, 32'h11);
    check("abort_no_done", d_v, 32'h0);
    run_i = 1'b0;
    collect(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
